alu_result_display: RTL and testbench

- Downstream consumer of the ALU's 16-bit `out` result bus.
- Filters out transient values: a result must be stable for a set number of cycles before it is latched.
- Time-multiplexes the latched value as four hex digits onto a common-anode seven-segment display, which is the board-level output of the lab datapath.
- Also exports the latched value and an update strobe for debug and bench checking.

---
 rtl/alu_result_display_pkg.sv | 13 +
 rtl/alu_result_display_if.sv | 12 +
 rtl/alu_result_display_hex_to_seg7.sv | 9 +
 rtl/alu_result_display.sv | 54 +++++
 tb/tb_alu_result_display.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/alu_result_display_pkg.sv
// alu_disp_pkg: seven-segment encodings and anode patterns shared by the result display
package alu_disp_pkg;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [3:0] AN_RESET  = 4'b1110;
    // active-low gfedcba shapes, entry F first so HEX_SEG[n] decodes nibble n
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, SEG_ZERO
    };
endpackage

// File: rtl/alu_result_display_if.sv
// alu_result_display_if: ALU result input and display/debug outputs of the result display
interface alu_result_display_if;
    logic [15:0] result;
    logic        freeze;
    logic [15:0] shown;
    logic        update;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    modport master (output result, freeze, input shown, update, seg, dp, an);
    modport slave  (input result, freeze, output shown, update, seg, dp, an);
endinterface

// File: rtl/alu_result_display_hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low seven-segment decode
module hex_to_seg7
    import alu_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/alu_result_display.sv
// alu_result_display: debounces the ALU result and scans it onto a 4-digit seven-segment display
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV   = 50000,
    parameter int DIV_WIDTH     = 16,
    parameter int STABLE_CYCLES = 4
) (
    input logic clk,
    input logic rst,
    alu_result_display_if.slave bus
);
    localparam int CNT_W = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_MAX = DIV_WIDTH'(REFRESH_DIV - 1);
    logic [15:0] cand, shown;
    logic [CNT_W-1:0] cnt;
    logic update;
    logic [DIV_WIDTH-1:0] div;
    logic [1:0] digit;
    logic same, commit, wrap;
    logic [3:0] nibble;
    logic [6:0] seg;
    always_comb begin
        same   = bus.result == cand;
        commit = same && cnt == CNT_MAX && cand != shown && !bus.freeze;
        wrap   = div == DIV_MAX;
        nibble = 4'(shown >> {digit, 2'b00});
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand   <= '0;
            cnt    <= '0;
            shown  <= '0;
            update <= 1'b0;
            div    <= '0;
            digit  <= '0;
        end else begin
            cand   <= bus.result;
            cnt    <= !same ? '0 : cnt == CNT_MAX ? cnt : cnt + 1'b1;
            shown  <= commit ? cand : shown;
            update <= commit;
            div    <= wrap ? '0 : div + 1'b1;
            digit  <= digit + 2'(wrap);
        end
    end
    hex_to_seg7 u_dec (.nibble(nibble), .seg(seg));
    // rotating the reset pattern left by digit walks the single low anode
    assign bus.an     = 4'({AN_RESET, AN_RESET} >> (3'd4 - {1'b0, digit}));
    assign bus.seg    = seg;
    assign bus.dp     = !(digit == 2'd0 && bus.freeze);
    assign bus.shown  = shown;
    assign bus.update = update;
endmodule

// File: tb/tb_alu_result_display.sv
// tb_alu_result_display: directed stimulus with a commit scoreboard checked by a separate monitor
module tb_alu_result_display;
    typedef struct {
        logic [15:0] v;
        int          c;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   rel = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    alu_result_display_if bus();
    alu_result_display #(.REFRESH_DIV(4), .DIV_WIDTH(16), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic to_digit(input int d);
        for (int i = 0; i < 16 && ((cyc - rel) / 4) % 4 != d; i++) @(negedge clk);
        chk($sformatf("an_digit%0d", d), bus.an, 16'(4'(~(4'b0001 << d))));
    endtask
    task automatic expect_commit(input logic [15:0] v, input int lat);
        exp_t e;
        e.v = v;
        e.c = cyc + lat;
        q.push_back(e);
    endtask
    initial forever begin
        @(negedge clk);
        if (rst && bus.update) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: shown=%h at cycle %0d, no commit expected", bus.shown, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.shown !== e.v || cyc != e.c) begin
                    errors++;
                    $display("FAIL commit: shown=%h cycle=%0d expected shown=%h cycle=%0d", bus.shown, cyc, e.v, e.c);
                end
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end
    initial begin
        rst = 1'b0;
        bus.result = 16'hFFFF;
        bus.freeze = 1'b0;
        #1;
        chk("rst_shown", bus.shown, 16'h0000);
        chk("rst_an", 16'(bus.an), 16'h000E);
        chk("rst_seg", 16'(bus.seg), 16'(7'b1000000));
        chk("rst_dp", 16'(bus.dp), 16'h0001);
        chk("rst_update", 16'(bus.update), 16'h0000);
        #249;
        bus.result = 16'h0024;
        rst = 1'b1;
        rel = cyc;
        expect_commit(16'h0024, 5);
        tick(6);
        chk("commit_shown", bus.shown, 16'h0024);
        to_digit(0);
        chk("seg_d0_4", 16'(bus.seg), 16'(7'b0011001));
        to_digit(1);
        chk("seg_d1_2", 16'(bus.seg), 16'(7'b0100100));
        for (int i = 0; i < 16 && (cyc - rel) % 16 != 0; i++) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("scan_an_k%0d", k), 16'(bus.an), 16'(4'(~(4'b0001 << (k / 4)))));
            if (k / 4 >= 2) chk($sformatf("scan_seg_k%0d", k), 16'(bus.seg), 16'(7'b1000000));
            tick(1);
        end
        chk("scan_wrap_an", 16'(bus.an), 16'h000E);
        for (int i = 0; i < 20; i++) begin
            bus.result = i % 2 ? 16'h0024 : 16'h000C;
            tick(2);
        end
        chk("glitch_shown", bus.shown, 16'h0024);
        bus.result = 16'h000C;
        expect_commit(16'h000C, 5);
        tick(8);
        chk("hold_shown", bus.shown, 16'h000C);
        to_digit(0);
        bus.freeze = 1'b1;
        bus.result = 16'h0009;
        #1;
        chk("freeze_dp_d0", 16'(bus.dp), 16'h0000);
        tick(10);
        chk("freeze_shown", bus.shown, 16'h000C);
        to_digit(1);
        chk("freeze_dp_d1", 16'(bus.dp), 16'h0001);
        bus.freeze = 1'b0;
        expect_commit(16'h0009, 1);
        tick(3);
        chk("unfreeze_shown", bus.shown, 16'h0009);
        for (int i = 0; i < 16 && !(((cyc + 3 - rel) / 4) % 4 == 2 && (cyc + 3 - rel) % 4 == 1); i++)
            @(negedge clk);
        bus.result = 16'h1234;
        tick(3);
        chk("pre_rst_an", 16'(bus.an), 16'h000B);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_shown", bus.shown, 16'h0000);
        chk("arst_an", 16'(bus.an), 16'h000E);
        chk("arst_seg", 16'(bus.seg), 16'(7'b1000000));
        chk("arst_dp", 16'(bus.dp), 16'h0001);
        chk("arst_update", 16'(bus.update), 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        rel = cyc;
        expect_commit(16'h1234, 5);
        tick(8);
        chk("rerun_shown", bus.shown, 16'h1234);
        to_digit(0);
        chk("seg_1234_d0", 16'(bus.seg), 16'(7'b0011001));
        to_digit(1);
        chk("seg_1234_d1", 16'(bus.seg), 16'(7'b0110000));
        tick(2);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_update: %0d expected commits never seen", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
